// File: rtl/shift_sequencer.sv
// shift_sequencer
// ---------------------------------------------------------------------------
// Iterative 32-bit shift engine shared by two requesters.
// - A round-robin arbiter picks one requester while the engine is idle.
// - The engine runs LSL, LSR, ASR or ROR by 0..31 bits, moving at most STEP
//   bit positions per cycle.
// - The result comes back on a valid/ready response tagged with the
//   requester id.
//
// Parameters
//   STEP        maximum bit positions shifted per SHIFT cycle (1..31)
//
// Ports
//   clk         clock, rising edge
//   reset       synchronous active-high reset
//   req_valid   per-requester request valid (bit i = requester i)
//   req_ready   per-requester accept, one-hot or zero, only while idle
//   reqN_data   requester N operand
//   reqN_sh     requester N op: 00 LSL, 01 LSR, 10 ASR, 11 ROR
//   reqN_amt    requester N shift amount (0..31)
//   rsp_valid   result valid
//   rsp_ready   consumer accepts result
//   rsp_id      requester index of the result
//   rsp_result  shifted value
//   rsp_carry   last bit shifted out (only when SHIFT_CARRY_EN is defined)
//   busy        high while an operation is in flight (SHIFT or DONE)
//
// Build option
//   SHIFT_CARRY_EN  adds rsp_carry and its tracking register.
// ---------------------------------------------------------------------------
module shift_sequencer #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req0_data,
  input  logic [1:0]  req0_sh,
  input  logic [4:0]  req0_amt,
  input  logic [31:0] req1_data,
  input  logic [1:0]  req1_sh,
  input  logic [4:0]  req1_amt,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
`ifdef SHIFT_CARRY_EN
  output logic        rsp_carry,
`endif
  output logic [31:0] rsp_result,
  output logic        busy
);

  localparam logic [4:0] STEP_K = 5'(STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_reg;
  logic        last_reg;       // requester granted most recently
  logic [31:0] value_reg;      // working value; holds the result in DONE
  logic [1:0]  op_reg;
  logic [4:0]  rem_reg;        // shift positions still to apply
  logic        id_reg;
  logic        rsp_valid_reg;

  logic        grant_id;
  logic        transfer;
  logic [31:0] sel_data;
  logic [1:0]  sel_sh;
  logic [4:0]  sel_amt;
  logic [4:0]  step_k;
  logic [31:0] value_next;

  // One partial shift by k (k <= 31). Rotate by zero is handled explicitly
  // so no 32-bit left shift is ever formed.
  function automatic logic [31:0] shift_step(input logic [31:0] v,
                                             input logic [1:0]  op,
                                             input logic [4:0]  k);
    logic [31:0] r;
    case (op)
      2'b00:   r = v << k;
      2'b01:   r = v >> k;
      2'b10:   r = 32'($signed(v) >>> k);
      default: begin
        if (k == 5'd0) r = v;
        else           r = (v >> k) | (v << (6'd32 - {1'b0, k}));
      end
    endcase
    return r;
  endfunction

  // Arbitration: with both requesters valid, the one not granted last wins;
  // otherwise whichever is valid.
  always_comb begin
    grant_id = 1'b0;
    if (req_valid == 2'b11) grant_id = ~last_reg;
    else                    grant_id = req_valid[1];
  end

  assign req_ready = (state_reg == IDLE) ?
                     {req_valid[1] & grant_id, req_valid[0] & ~grant_id} : 2'b00;
  assign transfer  = |req_ready;

  assign sel_data = grant_id ? req1_data : req0_data;
  assign sel_sh   = grant_id ? req1_sh   : req0_sh;
  assign sel_amt  = grant_id ? req1_amt  : req0_amt;

  assign step_k     = (rem_reg > STEP_K) ? STEP_K : rem_reg;
  assign value_next = shift_step(value_reg, op_reg, step_k);

  // rsp_valid is registered from the DONE state, so it rises one cycle after
  // DONE is entered; this gives 1 cycle for amt=0 and ceil(amt/STEP)+1 else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      last_reg      <= 1'b1;   // requester 0 wins the first contested grant
      value_reg     <= '0;
      op_reg        <= 2'b00;
      rem_reg       <= '0;
      id_reg        <= 1'b0;
      rsp_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (transfer) begin
            value_reg <= sel_data;
            op_reg    <= sel_sh;
            rem_reg   <= sel_amt;
            id_reg    <= grant_id;
            last_reg  <= grant_id;
            state_reg <= (sel_amt == 5'd0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          value_reg <= value_next;
          rem_reg   <= rem_reg - step_k;
          if (rem_reg == step_k) state_reg <= DONE;
        end
        DONE: begin
          if (rsp_valid_reg && rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end else begin
            rsp_valid_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_reg;
  assign rsp_result = value_reg;
  assign rsp_id     = id_reg;
  assign busy       = (state_reg != IDLE);

`ifdef SHIFT_CARRY_EN
  logic carry_reg;

  // Bit leaving the word on a partial shift by k (k >= 1): for LSL it is bit
  // 32-k; for LSR/ASR/ROR it is bit k-1 (for ROR that bit lands in bit 31).
  function automatic logic step_carry(input logic [31:0] v,
                                      input logic [1:0]  op,
                                      input logic [4:0]  k);
    logic [4:0] idx;
    logic       c;
    idx = (op == 2'b00) ? (5'd0 - k) : (k - 5'd1);
    c   = (k == 5'd0) ? 1'b0 : v[idx];
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      carry_reg <= 1'b0;
    end else if (state_reg == IDLE && transfer) begin
      carry_reg <= 1'b0;
    end else if (state_reg == SHIFT) begin
      carry_reg <= step_carry(value_reg, op_reg, step_k);
    end
  end

  assign rsp_carry = carry_reg;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer
// ---------------------------------------------------------------------------
// Self-checking bench for shift_sequencer (STEP=4).
// A transaction-level model (whole-amount shifts, latency formula, round-robin
// rule) predicts req_ready, busy, rsp_valid, rsp_id, rsp_result every cycle.
// A short table of directed transactions with hand-computed results pins the
// model; a randomized phase with occasional resets follows.
// Define SHIFT_CARRY_EN to also check rsp_carry.
// ---------------------------------------------------------------------------
module tb_shift_sequencer;
  localparam int STEP = 4;
  localparam int NDIR = 11;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_data, req1_data;
  logic [1:0]  req0_sh, req1_sh;
  logic [4:0]  req0_amt, req1_amt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        busy;
`ifdef SHIFT_CARRY_EN
  logic        rsp_carry;
`endif

  always #5 clk = ~clk;

  shift_sequencer #(.STEP(STEP)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_data  (req0_data),
    .req0_sh    (req0_sh),
    .req0_amt   (req0_amt),
    .req1_data  (req1_data),
    .req1_sh    (req1_sh),
    .req1_amt   (req1_amt),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
`ifdef SHIFT_CARRY_EN
    .rsp_carry  (rsp_carry),
`endif
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  // Directed transaction table, in handshake order.
  logic        t_id   [NDIR];
  logic [1:0]  t_sh   [NDIR];
  logic [31:0] t_data [NDIR];
  logic [4:0]  t_amt  [NDIR];
  logic [31:0] t_res  [NDIR];
  int          t_lat  [NDIR];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [31:0] v,
                                             input logic [1:0] op,
                                             input logic [4:0] amt);
    logic [63:0] w;
    case (op)
      2'b00:   w = {32'd0, v} << amt;
      2'b01:   w = {32'd0, v} >> amt;
      2'b10:   w = {{32{v[31]}}, v} >> amt;
      default: w = {v, v} >> amt;
    endcase
    return w[31:0];
  endfunction

  function automatic int ref_latency(input logic [4:0] amt);
    int a;
    a = int'(amt);
    return (a == 0) ? 1 : ((a + STEP - 1) / STEP + 1);
  endfunction

`ifdef SHIFT_CARRY_EN
  function automatic logic ref_carry(input logic [31:0] v,
                                     input logic [1:0] op,
                                     input logic [4:0] amt);
    int a;
    logic [31:0] r;
    a = int'(amt);
    r = ref_result(v, op, amt);
    if (a == 0)          return 1'b0;
    else if (op == 2'b00) return 1'(v >> (32 - a));
    else if (op == 2'b11) return r[31];
    else                 return 1'(v >> (a - 1));
  endfunction
`endif

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s cycle=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  // ---------------- compare process ----------------
  logic        m_init = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_last = 1'b1;
  int          m_acc  = 0;
  int          m_lat  = 0;
  logic [31:0] m_res  = '0;
  logic        m_id   = 1'b0;
  logic        m_seen = 1'b0;
  int          m_obs  = 0;
  logic        post_reset = 1'b0;
  int          hs_count = 0;
`ifdef SHIFT_CARRY_EN
  logic        m_car = 1'b0;
`endif
  logic [1:0]  exp_ready;
  logic        g;
  logic        exp_rv;

  always @(negedge clk) begin
    if (reset) begin
      m_init     = 1'b1;
      m_busy     = 1'b0;
      m_last     = 1'b1;
      m_seen     = 1'b0;
      post_reset = 1'b1;
    end else if (m_init) begin
      if (post_reset) begin
        chk("reset_result", rsp_result, 32'h0);
        chk("reset_id", 32'(rsp_id), 32'h0);
        post_reset = 1'b0;
      end
      if (req_valid == 2'b11) g = ~m_last;
      else                    g = req_valid[1];
      if (m_busy || req_valid == 2'b00) exp_ready = 2'b00;
      else                              exp_ready = g ? 2'b10 : 2'b01;
      exp_rv = m_busy && ((cyc - m_acc) >= m_lat);

      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv) begin
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
`ifdef SHIFT_CARRY_EN
        chk("rsp_carry", 32'(rsp_carry), 32'(m_car));
`endif
      end
      if (m_busy && rsp_valid && !m_seen) begin
        m_seen = 1'b1;
        m_obs  = cyc - m_acc;
      end

      if (!m_busy && exp_ready != 2'b00) begin
        m_busy = 1'b1;
        m_acc  = cyc + 1;
        m_id   = g;
        m_last = g;
        m_seen = 1'b0;
        if (g) begin
          m_lat = ref_latency(req1_amt);
          m_res = ref_result(req1_data, req1_sh, req1_amt);
`ifdef SHIFT_CARRY_EN
          m_car = ref_carry(req1_data, req1_sh, req1_amt);
`endif
        end else begin
          m_lat = ref_latency(req0_amt);
          m_res = ref_result(req0_data, req0_sh, req0_amt);
`ifdef SHIFT_CARRY_EN
          m_car = ref_carry(req0_data, req0_sh, req0_amt);
`endif
        end
      end else if (exp_rv && rsp_ready) begin
        if (hs_count < NDIR) begin
          chk("dir_result", rsp_result, t_res[hs_count]);
          chk("dir_id", 32'(rsp_id), 32'(t_id[hs_count]));
          chk("dir_lat_model", 32'(m_lat), 32'(t_lat[hs_count]));
          chk("dir_lat_dut", 32'(m_obs), 32'(t_lat[hs_count]));
        end
        hs_count = hs_count + 1;
        m_busy   = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tab(input int i, input logic id, input logic [1:0] sh,
                     input logic [31:0] d, input logic [4:0] amt,
                     input logic [31:0] res, input int lat);
    t_id[i] = id; t_sh[i] = sh; t_data[i] = d;
    t_amt[i] = amt; t_res[i] = res; t_lat[i] = lat;
  endtask

  task automatic set_req(input logic id, input logic [31:0] d,
                         input logic [1:0] sh, input logic [4:0] amt);
    if (id) begin
      req1_data = d; req1_sh = sh; req1_amt = amt;
    end else begin
      req0_data = d; req0_sh = sh; req0_amt = amt;
    end
    req_valid[id] = 1'b1;
  endtask

  task automatic wait_accept(input logic id);
    @(negedge clk);
    for (int n = 0; n < 100 && !req_ready[id]; n++) @(negedge clk);
    if (!req_ready[id]) begin
      $display("FAIL accept_timeout id=%0d got=0 exp=1", id);
      $fatal(1);
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp();
    @(negedge clk);
    for (int n = 0; n < 100 && !(rsp_valid && rsp_ready); n++) @(negedge clk);
    if (!(rsp_valid && rsp_ready)) begin
      $display("FAIL rsp_timeout got=0 exp=1");
      $fatal(1);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_entry(input int i);
    set_req(t_id[i], t_data[i], t_sh[i], t_amt[i]);
    wait_accept(t_id[i]);
    wait_rsp();
  endtask

  initial begin
    int nacc;
    tab(0,  1'b0, 2'b00, 32'h0000_0001, 5'd5,  32'h0000_0020, 3);
    tab(1,  1'b1, 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 9);
    tab(2,  1'b0, 2'b11, 32'h0000_00F1, 5'd4,  32'h1000_000F, 2);
    tab(3,  1'b0, 2'b11, 32'h1234_5678, 5'd0,  32'h1234_5678, 1);
    tab(4,  1'b1, 2'b01, 32'hF000_0000, 5'd8,  32'h00F0_0000, 3);
    tab(5,  1'b0, 2'b00, 32'h0000_0001, 5'd0,  32'h0000_0001, 1);
    tab(6,  1'b0, 2'b00, 32'h0000_0003, 5'd1,  32'h0000_0006, 2);
    tab(7,  1'b1, 2'b01, 32'h8000_0001, 5'd1,  32'h4000_0000, 2);
    tab(8,  1'b0, 2'b00, 32'h0000_0003, 5'd1,  32'h0000_0006, 2);
    tab(9,  1'b1, 2'b01, 32'h8000_0001, 5'd1,  32'h4000_0000, 2);
    tab(10, 1'b1, 2'b11, 32'h8000_0001, 5'd1,  32'hC000_0000, 2);

    reset = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
    req0_data = '0; req0_sh = '0; req0_amt = '0;
    req1_data = '0; req1_sh = '0; req1_amt = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 4; i++) run_entry(i);

    // Consumer stalls in DONE while requester 0 waits.
    rsp_ready = 1'b0;
    set_req(t_id[4], t_data[4], t_sh[4], t_amt[4]);
    wait_accept(t_id[4]);
    for (int n = 0; n < 100 && !rsp_valid; n++) @(negedge clk);
    @(posedge clk); #1;
    set_req(t_id[5], t_data[5], t_sh[5], t_amt[5]);
    repeat (4) @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_rsp();
    wait_accept(t_id[5]);
    wait_rsp();

    // Fresh reset, then both requesters held valid for four transactions.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    set_req(1'b0, t_data[6], t_sh[6], t_amt[6]);
    set_req(1'b1, t_data[7], t_sh[7], t_amt[7]);
    nacc = 0;
    for (int n = 0; n < 200 && nacc < 4; n++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != 2'b00) nacc = nacc + 1;
    end
    if (nacc < 4) begin
      $display("FAIL both_valid_timeout got=%0d exp=4", nacc);
      $fatal(1);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_rsp();

    // Reset while shifting discards the operation.
    set_req(1'b0, 32'hFFFF_FFFF, 2'b01, 5'd20);
    wait_accept(1'b0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    run_entry(10);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      req_valid = 2'($urandom_range(0, 3));
      req0_data = $urandom();
      req0_sh   = 2'($urandom_range(0, 3));
      req0_amt  = 5'($urandom_range(0, 31));
      req1_data = $urandom();
      req1_sh   = 2'($urandom_range(0, 3));
      req1_amt  = 5'($urandom_range(0, 31));
      rsp_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 249) == 0);
    end
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
    repeat (40) @(posedge clk);

    if (hs_count < NDIR) begin
      checks   = checks;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
